// File: rtl/cnn_layer_accel_layer_engine_pe_buf.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_layer_engine_pe_buf
//   Per-PE packet stage between the layer engine router and the PE datapath.
//   Each of C_NUM_PE channels has an independent rd path and wr path. Every
//   path is a C_FIFO_DEPTH elastic buffer with a runtime mode:
//     mode=0 SINK : accept everything, drop it, never present output.
//     mode=1 PASS : buffered forwarding with valid/accept backpressure.
//
// Ports (rd shown, wr identical):
//   clk, rst                    clock, async active-low reset
//   mode_rd[C_NUM_PE]           per-channel mode
//   layer_eng_rd_input_*        valid/accept/data from the router
//   layer_eng_rd_output_*       valid/accept/data to the PE
//   data buses pack channel i at [i*C_PACKET_WIDTH +: C_PACKET_WIDTH]
//
// Optional: define CNN_LAYER_ACCEL_PE_BUF_STATS_EN to add saturating 16-bit
//   per-channel counters pkt_cnt_rd, pkt_cnt_wr (input transfers) and
//   drop_cnt (rd+wr packets discarded by SINK mode or flush).
// ---------------------------------------------------------------------------

module cnn_layer_accel_layer_engine_pe_buf_path #(
  parameter int PW    = 66,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_i,
  input  logic          in_valid_i,
  output logic          in_accept_o,
  input  logic [PW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_accept_i,
  output logic [PW-1:0] out_data_o
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
  ,
  output logic                       in_xfer_o,
  output logic [$clog2(DEPTH):0]     drop_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][PW-1:0] mem_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, drop;
  logic          acc_q, acc_d;
  logic          push, pop;

  // accept is a register, so push never depends on out_accept_i
  assign push = in_valid_i & acc_q;
  assign pop  = (cnt_q != '0) & out_accept_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    drop  = '0;
    if (!mode_i) begin
      // SINK (or PASS->SINK switch): flush, drop anything arriving now
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      acc_d = 1'b1;
      drop  = cnt_q - CW'(pop) + CW'(push);
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      acc_d = cnt_d < CW'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // storage needs no reset: it is only visible while cnt_q != 0
  always_ff @(posedge clk) begin
    if (mode_i && push) mem_q[wr_q] <= in_data_i;
  end

  assign in_accept_o = acc_q;
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;

`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
  assign in_xfer_o = push;
  assign drop_o    = drop;
`endif
endmodule

module cnn_layer_accel_layer_engine_pe_buf #(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_PE       = 4,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [C_NUM_PE-1:0]                mode_rd,
  input  logic [C_NUM_PE-1:0]                mode_wr,
  input  logic [C_NUM_PE-1:0]                layer_eng_rd_input_valid,
  output logic [C_NUM_PE-1:0]                layer_eng_rd_input_accept,
  input  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_rd_input_data,
  output logic [C_NUM_PE-1:0]                layer_eng_rd_output_valid,
  input  logic [C_NUM_PE-1:0]                layer_eng_rd_output_accept,
  output logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_rd_output_data,
  input  logic [C_NUM_PE-1:0]                layer_eng_wr_input_valid,
  output logic [C_NUM_PE-1:0]                layer_eng_wr_input_accept,
  input  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_wr_input_data,
  output logic [C_NUM_PE-1:0]                layer_eng_wr_output_valid,
  input  logic [C_NUM_PE-1:0]                layer_eng_wr_output_accept,
  output logic [C_PACKET_WIDTH*C_NUM_PE-1:0] layer_eng_wr_output_data
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
  ,
  output logic [16*C_NUM_PE-1:0]             pkt_cnt_rd,
  output logic [16*C_NUM_PE-1:0]             pkt_cnt_wr,
  output logic [16*C_NUM_PE-1:0]             drop_cnt
`endif
);
  localparam int PW = C_PACKET_WIDTH;

  for (genvar g = 0; g < C_NUM_PE; g++) begin : g_ch
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
    localparam int DW = $clog2(C_FIFO_DEPTH) + 1;
    logic          xfer_rd, xfer_wr;
    logic [DW-1:0] drop_rd, drop_wr;
`endif

    cnn_layer_accel_layer_engine_pe_buf_path #(.PW(PW), .DEPTH(C_FIFO_DEPTH)) u_rd (
      .clk          (clk),
      .rst          (rst),
      .mode_i       (mode_rd[g]),
      .in_valid_i   (layer_eng_rd_input_valid[g]),
      .in_accept_o  (layer_eng_rd_input_accept[g]),
      .in_data_i    (layer_eng_rd_input_data[g*PW +: PW]),
      .out_valid_o  (layer_eng_rd_output_valid[g]),
      .out_accept_i (layer_eng_rd_output_accept[g]),
      .out_data_o   (layer_eng_rd_output_data[g*PW +: PW])
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
      ,
      .in_xfer_o    (xfer_rd),
      .drop_o       (drop_rd)
`endif
    );

    cnn_layer_accel_layer_engine_pe_buf_path #(.PW(PW), .DEPTH(C_FIFO_DEPTH)) u_wr (
      .clk          (clk),
      .rst          (rst),
      .mode_i       (mode_wr[g]),
      .in_valid_i   (layer_eng_wr_input_valid[g]),
      .in_accept_o  (layer_eng_wr_input_accept[g]),
      .in_data_i    (layer_eng_wr_input_data[g*PW +: PW]),
      .out_valid_o  (layer_eng_wr_output_valid[g]),
      .out_accept_i (layer_eng_wr_output_accept[g]),
      .out_data_o   (layer_eng_wr_output_data[g*PW +: PW])
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
      ,
      .in_xfer_o    (xfer_wr),
      .drop_o       (drop_wr)
`endif
    );

`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
    logic [15:0] prd_q, pwr_q, drp_q;
    logic [16:0] dsum;

    // rd and wr may both drop in one cycle; sum wide, then clamp
    assign dsum = 17'(drp_q) + 17'(drop_rd) + 17'(drop_wr);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        prd_q <= '0;
        pwr_q <= '0;
        drp_q <= '0;
      end else begin
        if (xfer_rd && prd_q != 16'hFFFF) prd_q <= prd_q + 16'd1;
        if (xfer_wr && pwr_q != 16'hFFFF) pwr_q <= pwr_q + 16'd1;
        drp_q <= dsum[16] ? 16'hFFFF : dsum[15:0];
      end
    end

    assign pkt_cnt_rd[g*16 +: 16] = prd_q;
    assign pkt_cnt_wr[g*16 +: 16] = pwr_q;
    assign drop_cnt[g*16 +: 16]   = drp_q;
`endif
  end
endmodule

// File: tb/tb_cnn_layer_accel_layer_engine_pe_buf.sv
module tb_cnn_layer_accel_layer_engine_pe_buf;
  localparam int PW = 66;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int NP = 2 * N;  // paths 0..3 rd ch0..3, 4..7 wr ch0..3

  typedef logic [PW-1:0] pkt_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] mode_rd, mode_wr;
  logic [N-1:0] rd_iv, rd_ia, rd_ov, rd_oa, wr_iv, wr_ia, wr_ov, wr_oa;
  logic [N*PW-1:0] rd_id, rd_od, wr_id, wr_od;
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
  logic [16*N-1:0] pkt_cnt_rd, pkt_cnt_wr, drop_cnt;
`endif

  always #5 clk = ~clk;

  cnn_layer_accel_layer_engine_pe_buf #(
    .C_PACKET_WIDTH(PW), .C_NUM_PE(N), .C_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .mode_rd(mode_rd), .mode_wr(mode_wr),
    .layer_eng_rd_input_valid(rd_iv), .layer_eng_rd_input_accept(rd_ia),
    .layer_eng_rd_input_data(rd_id), .layer_eng_rd_output_valid(rd_ov),
    .layer_eng_rd_output_accept(rd_oa), .layer_eng_rd_output_data(rd_od),
    .layer_eng_wr_input_valid(wr_iv), .layer_eng_wr_input_accept(wr_ia),
    .layer_eng_wr_input_data(wr_id), .layer_eng_wr_output_valid(wr_ov),
    .layer_eng_wr_output_accept(wr_oa), .layer_eng_wr_output_data(wr_od)
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
    , .pkt_cnt_rd(pkt_cnt_rd), .pkt_cnt_wr(pkt_cnt_wr), .drop_cnt(drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stimulus per path
  bit   sv[NP];
  pkt_t sd[NP];
  bit   sa[NP];
  bit   md[NP];

  // reference: each path is a bounded queue; accept is decided from the
  // occupancy seen after the previous edge
  pkt_t mq[NP][$];
  bit   m_acc[NP];
  int   m_pkt[NP];
  int   m_drop[N];
  bit   ix[NP], ox[NP];
  int   dut_pops[NP];

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic apply();
    for (int c = 0; c < N; c++) begin
      mode_rd[c] = md[c];       mode_wr[c] = md[c+N];
      rd_iv[c]   = sv[c];       wr_iv[c]   = sv[c+N];
      rd_oa[c]   = sa[c];       wr_oa[c]   = sa[c+N];
      rd_id[c*PW +: PW] = sd[c];
      wr_id[c*PW +: PW] = sd[c+N];
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      m_acc[p] = 1'b0;
      m_pkt[p] = 0;
    end
    for (int c = 0; c < N; c++) m_drop[c] = 0;
  endtask

  // one clock: check at negedge, advance reference at posedge
  task automatic cyc();
    apply();
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      int   c;
      bit   w, ev;
      logic ga, gv;
      pkt_t gd, ed;
      c  = p % N;
      w  = (p >= N);
      ga = w ? wr_ia[c] : rd_ia[c];
      gv = w ? wr_ov[c] : rd_ov[c];
      gd = w ? wr_od[c*PW +: PW] : rd_od[c*PW +: PW];
      ev = (mq[p].size() > 0);
      ed = ev ? mq[p][0] : '0;
      chk($sformatf("acc%0d", p), 128'(ga), 128'(m_acc[p]));
      chk($sformatf("vld%0d", p), 128'(gv), 128'(ev));
      chk($sformatf("dat%0d", p), 128'(gd), 128'(ed));
      ix[p] = sv[p] && m_acc[p];
      ox[p] = ev && sa[p];
      if (gv === 1'b1 && sa[p]) dut_pops[p]++;
    end
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
    for (int c = 0; c < N; c++) begin
      chk($sformatf("pkt_rd%0d", c), 128'(pkt_cnt_rd[c*16 +: 16]), 128'(sat16(m_pkt[c])));
      chk($sformatf("pkt_wr%0d", c), 128'(pkt_cnt_wr[c*16 +: 16]), 128'(sat16(m_pkt[c+N])));
      chk($sformatf("drop%0d", c),   128'(drop_cnt[c*16 +: 16]),   128'(sat16(m_drop[c])));
    end
`endif
    @(posedge clk);
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        if (ix[p]) m_pkt[p]++;
        if (!md[p]) begin
          m_drop[p % N] += mq[p].size() - int'(ox[p]) + int'(ix[p]);
          mq[p].delete();
          m_acc[p] = 1'b1;
        end else begin
          if (ox[p]) void'(mq[p].pop_front());
          if (ix[p]) mq[p].push_back(sd[p]);
          m_acc[p] = (mq[p].size() < D);
        end
      end
    end else begin
      for (int p = 0; p < NP; p++) begin ix[p] = 1'b0; ox[p] = 1'b0; end
    end
    #1;
  endtask

  initial begin
    int k, start, guard;
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      sv[p] = 0; sd[p] = '0; sa[p] = 0; md[p] = 0; dut_pops[p] = 0;
    end
    model_reset();
    apply();
    #1;
    chk("rst_ia", 128'({wr_ia, rd_ia}), 128'(0));
    chk("rst_ov", 128'({wr_ov, rd_ov}), 128'(0));
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();
    chk("rel_ia_rd", 128'(rd_ia), 128'(4'hF));
    chk("rel_ia_wr", 128'(wr_ia), 128'(4'hF));

    // SINK: 10 packets on ch0 rd vanish
    sv[0] = 1;
    for (int i = 1; i <= 10; i++) begin sd[0] = pkt_t'(i); cyc(); end
    sv[0] = 0;
    cyc();
    chk("sink_pops", 128'(dut_pops[0]), 128'(0));
`ifdef CNN_LAYER_ACCEL_PE_BUF_STATS_EN
    chk("sink_drop", 128'(drop_cnt[15:0]), 128'(10));
`endif

    // PASS ch1 rd, blocked downstream: fills to depth
    md[1] = 1; cyc();
    k = 1; sv[1] = 1; sd[1] = pkt_t'(1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ix[1]) begin k++; sd[1] = pkt_t'(k); if (k > 6) sv[1] = 0; end
    end
    chk("full_ia", 128'(rd_ia[1]), 128'(0));
    chk("full_head", 128'(rd_od[PW +: PW]), 128'(1));
    sa[1] = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ix[1]) begin k++; sd[1] = pkt_t'(k); if (k > 6) sv[1] = 0; end
    end
    sv[1] = 0;
    chk("pass_pops", 128'(dut_pops[1]), 128'(6));

    // throughput on ch2 wr: 100 packets back to back
    md[6] = 1; sa[6] = 1; cyc();
    start = dut_pops[6];
    k = 0; sv[6] = 1; sd[6] = '0;
    for (int i = 0; i < 101; i++) begin
      cyc();
      if (ix[6]) begin k++; sd[6] = pkt_t'(k); if (k == 100) sv[6] = 0; end
    end
    chk("thru_in", 128'(k), 128'(100));
    chk("thru_out", 128'(dut_pops[6] - start), 128'(100));

    // ch3 rd: hold 3, flush by SINK, reopen
    md[3] = 1; sa[3] = 0; cyc();
    k = 0; sv[3] = 1; sd[3] = pkt_t'(8'h31); guard = 0;
    while (k < 3 && guard < 10) begin
      cyc(); guard++;
      if (ix[3]) begin k++; sd[3] = pkt_t'(8'h31 + k); end
    end
    sv[3] = 0;
    chk("hold3", 128'(k), 128'(3));
    md[3] = 0; cyc(); cyc();
    chk("flush_vld", 128'(rd_ov[3]), 128'(0));
    md[3] = 1; cyc();
    sv[3] = 1; sd[3] = pkt_t'(8'hAB); sa[3] = 1; guard = 0;
    while (rd_ov[3] !== 1'b1 && guard < 10) begin
      cyc(); guard++;
      if (ix[3]) sv[3] = 0;
    end
    chk("reopen_head", 128'(rd_od[3*PW +: PW]), 128'(8'hAB));
    sv[3] = 0; cyc(); cyc();

    // async reset with 2 packets held on ch0 rd
    md[0] = 1; sa[0] = 0; cyc();
    sv[0] = 1; sd[0] = pkt_t'(8'h71); k = 0; guard = 0;
    while (k < 2 && guard < 10) begin
      cyc(); guard++;
      if (ix[0]) begin k++; sd[0] = pkt_t'(8'h71 + k); end
    end
    sv[0] = 0; apply();
    chk("pre_rst_vld", 128'(rd_ov[0]), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", 128'(rd_ov[0]), 128'(0));
    chk("arst_ia", 128'(rd_ia), 128'(0));
    chk("arst_dat", 128'(rd_od[PW-1:0]), 128'(0));
    model_reset();
    cyc(); cyc();
    rst = 1'b1;
    sa[0] = 1; start = dut_pops[0];
    for (int i = 0; i < 5; i++) cyc();
    chk("no_stale", 128'(dut_pops[0] - start), 128'(0));

    // random traffic on all 8 paths; ch1 wr stalled for a window
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0)
        for (int p = 0; p < NP; p++) md[p] = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) begin
        if (!sv[p] || ix[p]) begin
          sv[p] = $urandom_range(0, 1);
          sd[p] = pkt_t'({$urandom, $urandom, $urandom});
        end
        sa[p] = $urandom_range(0, 1);
      end
      if (i >= 3000 && i < 4000) sa[5] = 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
